// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU controller: controller states, IR field positions, word width.
// The TRAP state only exists when HACK_CPU_TRAP_EN is defined.
package hack_pkg;

  localparam int WORD_W = 16;

  localparam int OP_BIT = 15;
  localparam int A_BIT  = 12;
  localparam int C_MSB  = 11;
  localparam int C_LSB  = 6;
  localparam int D_A    = 5;
  localparam int D_D    = 4;
  localparam int D_M    = 3;
  localparam int J_LT   = 2;
  localparam int J_EQ   = 1;
  localparam int J_GT   = 0;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_MREAD,
    ST_EXEC,
    ST_MWRITE
`ifdef HACK_CPU_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

endpackage

// File: rtl/hack_jump_unit.sv
// Combinational Hack jump condition: lt/eq/gt bits qualified by the ALU zero and negative flags.
module hack_jump_unit
  import hack_pkg::*;
(
  input  logic [2:0] i_jbits,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_take_jump
);

  assign o_take_jump = (i_jbits[J_LT] & i_ng) |
                       (i_jbits[J_EQ] & i_zr) |
                       (i_jbits[J_GT] & ~i_zr & ~i_ng);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU controller owning A, D and PC; sequences fetch, data memory and ALU use.
// Define HACK_CPU_TRAP_EN to halt in TRAP on C-instructions whose IR[14:13] is not 2'b11.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
)
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [WORD_W-1:0] o_imem_addr,
  output logic              o_imem_req,
  input  logic              i_imem_valid,
  input  logic [WORD_W-1:0] i_imem_data,
  output logic [WORD_W-1:0] o_dmem_addr,
  output logic              o_dmem_rd,
  output logic              o_dmem_wr,
  output logic [WORD_W-1:0] o_dmem_wdata,
  input  logic [WORD_W-1:0] i_dmem_rdata,
  input  logic              i_dmem_ack,
  output logic [WORD_W-1:0] o_alu_x,
  output logic [WORD_W-1:0] o_alu_y,
  output logic              o_alu_zx,
  output logic              o_alu_nx,
  output logic              o_alu_zy,
  output logic              o_alu_ny,
  output logic              o_alu_f,
  output logic              o_alu_no,
  input  logic [WORD_W-1:0] i_alu_out,
  input  logic              i_alu_zr,
  input  logic              i_alu_ng,
  output logic              o_trap
);

  state_t            r_state;
  logic [WORD_W-1:0] r_a, r_d, r_pc, r_ir, r_maddr, r_mreg, r_wdata;
  logic              r_imem_req, r_dmem_rd, r_dmem_wr;
  logic              w_take_jump, w_is_exec, w_sel_m;

  assign w_sel_m   = r_ir[A_BIT];
  assign w_is_exec = (r_state == ST_EXEC);

  hack_jump_unit u_jump (
    .i_jbits     (r_ir[J_LT:J_GT]),
    .i_zr        (i_alu_zr),
    .i_ng        (i_alu_ng),
    .o_take_jump (w_take_jump)
  );

`ifdef HACK_CPU_TRAP_EN
  logic r_trap;
  assign o_trap = r_trap;
`else
  assign o_trap = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_BOOT;
      r_a        <= '0;
      r_d        <= '0;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_maddr    <= '0;
      r_mreg     <= '0;
      r_wdata    <= '0;
      r_imem_req <= 1'b0;
      r_dmem_rd  <= 1'b0;
      r_dmem_wr  <= 1'b0;
`ifdef HACK_CPU_TRAP_EN
      r_trap     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (i_imem_valid) begin
            r_ir       <= i_imem_data;
            r_maddr    <= r_a;
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!r_ir[OP_BIT]) begin
            r_a        <= {1'b0, r_ir[OP_BIT-1:0]};
            r_pc       <= r_pc + WORD_W'(1);
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end
`ifdef HACK_CPU_TRAP_EN
          else if (r_ir[14:13] != 2'b11) begin
            r_trap  <= 1'b1;
            r_state <= ST_TRAP;
          end
`endif
          else if (w_sel_m) begin
            r_dmem_rd <= 1'b1;
            r_state   <= ST_MREAD;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_MREAD: begin
          if (i_dmem_ack) begin
            r_mreg    <= i_dmem_rdata;
            r_dmem_rd <= 1'b0;
            r_state   <= ST_EXEC;
          end
        end
        // Jump target is the A value from before this instruction's own A update.
        ST_EXEC: begin
          if (r_ir[D_A]) r_a <= i_alu_out;
          if (r_ir[D_D]) r_d <= i_alu_out;
          r_pc    <= w_take_jump ? r_a : r_pc + WORD_W'(1);
          r_wdata <= i_alu_out;
          if (r_ir[D_M]) begin
            r_dmem_wr <= 1'b1;
            r_state   <= ST_MWRITE;
          end else begin
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_MWRITE: begin
          if (i_dmem_ack) begin
            r_dmem_wr  <= 1'b0;
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign o_imem_addr  = r_pc;
  assign o_imem_req   = r_imem_req;
  assign o_dmem_addr  = r_maddr;
  assign o_dmem_rd    = r_dmem_rd;
  assign o_dmem_wr    = r_dmem_wr;
  assign o_dmem_wdata = r_wdata;

  assign o_alu_x = w_is_exec ? r_d : '0;
  assign o_alu_y = w_is_exec ? (w_sel_m ? r_mreg : r_a) : '0;
  assign {o_alu_zx, o_alu_nx, o_alu_zy, o_alu_ny, o_alu_f, o_alu_no} =
    w_is_exec ? r_ir[C_MSB:C_LSB] : 6'b0;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: ISA-level reference model, memories with random wait states.
// Builds with or without HACK_CPU_TRAP_EN.
module tb_hack_cpu_ctrl;

  localparam logic [15:0] RESET_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [15:0] imemAddr, imemData, dmemAddr, dmemWdata, dmemRdata;
  logic [15:0] aluX, aluY, aluOut;
  logic        imemReq, imemValid, dmemRd, dmemWr, dmemAck;
  logic        aluZx, aluNx, aluZy, aluNy, aluF, aluNo, aluZr, aluNg, trap;

  logic [15:0] imem [0:65535];
  logic [15:0] dmem [0:65535];
  logic [15:0] mA, mD, mPC;
  int          checkCount = 0;
  int          errorCount = 0;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .o_imem_addr(imemAddr), .o_imem_req(imemReq),
    .i_imem_valid(imemValid), .i_imem_data(imemData),
    .o_dmem_addr(dmemAddr), .o_dmem_rd(dmemRd), .o_dmem_wr(dmemWr),
    .o_dmem_wdata(dmemWdata), .i_dmem_rdata(dmemRdata), .i_dmem_ack(dmemAck),
    .o_alu_x(aluX), .o_alu_y(aluY),
    .o_alu_zx(aluZx), .o_alu_nx(aluNx), .o_alu_zy(aluZy),
    .o_alu_ny(aluNy), .o_alu_f(aluF), .o_alu_no(aluNo),
    .i_alu_out(aluOut), .i_alu_zr(aluZr), .i_alu_ng(aluNg),
    .o_trap(trap)
  );

  // Behavioural Hack ALU: the CPU's combinational partner in the system.
  function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'h0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0 : y;
    if (c[2]) yy = ~yy;
    r = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~r : r;
  endfunction

  assign aluOut = hackAlu(aluX, aluY, {aluZx, aluNx, aluZy, aluNy, aluF, aluNo});
  assign aluZr  = (aluOut == 16'h0);
  assign aluNg  = aluOut[15];

  function automatic logic [15:0] genInstr();
    logic [15:0] r;
    r = 16'($urandom);
`ifdef HACK_CPU_TRAP_EN
    if (r[15]) r[14:13] = 2'b11;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput(tag, {imemReq, dmemRd, dmemWr, trap, aluZx, aluNx, aluZy, aluNy, aluF, aluNo,
                      aluX, aluY}, 64'h0);
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    imemValid = 1'b0;
    dmemAck = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("reset_outputs");
    rstN = 1'b1;
    checkIdle("boot_outputs");
    mA = 16'h0;
    mD = 16'h0;
    mPC = RESET_PC;
    @(negedge clk);
  endtask

  // One instruction from FETCH onward; returns at the negedge of the next FETCH.
  task automatic applyStimulus(input int waitI, input int waitD, input bit abortWrite);
    logic [15:0] instr, yVal, res, oldA;
    bit          jump;
    instr = imem[mPC];
    for (int i = 0; i < waitI; i++) begin
      checkOutput("fetch_wait", {imemReq, dmemRd, dmemWr, imemAddr}, {3'b100, mPC});
      @(negedge clk);
    end
    checkOutput("fetch", {imemReq, dmemRd, dmemWr, imemAddr}, {3'b100, mPC});
    imemValid = 1'b1;
    imemData = instr;
    @(negedge clk);
    imemData = 16'($urandom);
    checkIdle("decode_idle");
    imemValid = 1'($urandom_range(0, 1));
    dmemAck = 1'($urandom_range(0, 1));
    @(negedge clk);
    imemValid = 1'b0;
    dmemAck = 1'b0;
    if (!instr[15]) begin
      mA = {1'b0, instr[14:0]};
      mPC = mPC + 16'd1;
      return;
    end
    oldA = mA;
    if (instr[12]) begin
      for (int i = 0; i < waitD; i++) begin
        checkOutput("mread_wait", {imemReq, dmemRd, dmemWr, dmemAddr}, {3'b010, oldA});
        @(negedge clk);
      end
      checkOutput("mread", {imemReq, dmemRd, dmemWr, dmemAddr}, {3'b010, oldA});
      dmemAck = 1'b1;
      dmemRdata = dmem[oldA];
      @(negedge clk);
      dmemAck = 1'b0;
      dmemRdata = 16'($urandom);
      yVal = dmem[oldA];
    end else begin
      yVal = mA;
    end
    res = hackAlu(mD, yVal, instr[11:6]);
    checkOutput("exec_x", aluX, mD);
    checkOutput("exec_y", aluY, yVal);
    checkOutput("exec_ctrl", {imemReq, dmemRd, dmemWr, aluZx, aluNx, aluZy, aluNy, aluF, aluNo},
                {3'b000, instr[11:6]});
    jump = (instr[2] && $signed(res) < 0) || (instr[1] && res == 16'h0) ||
           (instr[0] && $signed(res) > 0);
    mPC = jump ? oldA : mPC + 16'd1;
    if (instr[5]) mA = res;
    if (instr[4]) mD = res;
    @(negedge clk);
    if (instr[3]) begin
      for (int i = 0; i < waitD; i++) begin
        checkOutput("mwrite_wait", {imemReq, dmemRd, dmemWr, dmemAddr, dmemWdata},
                    {3'b001, oldA, res});
        @(negedge clk);
      end
      checkOutput("mwrite", {imemReq, dmemRd, dmemWr, dmemAddr, dmemWdata}, {3'b001, oldA, res});
      if (abortWrite) begin
        rstN = 1'b0;
        #1;
        checkIdle("reset_mid_write");
        return;
      end
      dmemAck = 1'b1;
      @(negedge clk);
      dmemAck = 1'b0;
      dmem[oldA] = res;
    end
  endtask

  initial begin
    logic [15:0] prog [0:11];
    imemValid = 1'b0;
    dmemAck = 1'b0;
    imemData = 16'h0;
    dmemRdata = 16'h0;
    for (int i = 0; i < 65536; i++) begin
      imem[i] = genInstr();
      dmem[i] = 16'($urandom);
    end
    prog = '{16'h0005, 16'hEC10, 16'h0003, 16'hEC10, 16'h0007, 16'hF1D8,
             16'hEA90, 16'h0020, 16'hE302, 16'hEFD0, 16'h0020, 16'hE302};
    for (int i = 0; i < 9; i++) imem[16'h0010 + 16'(i)] = prog[i];
    for (int i = 9; i < 12; i++) imem[16'h0020 + 16'(i - 9)] = prog[i];
    dmem[7] = 16'h0004;

    $display("[TB] directed program from RESET_PC");
    resetDut();
    for (int i = 0; i < 12; i++) applyStimulus((i == 5) ? 3 : 0, (i == 5) ? 2 : 0, 1'b0);
    checkOutput("directed_end_pc", imemAddr, 16'h0023);

    $display("[TB] random program with random wait states");
    repeat (300) applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

    $display("[TB] reset during MWRITE");
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 1, 1'b1);
    resetDut();
    for (int i = 0; i < 12; i++) applyStimulus($urandom_range(0, 2), $urandom_range(0, 2), 1'b0);

`ifdef HACK_CPU_TRAP_EN
    $display("[TB] illegal instruction trap");
    imem[RESET_PC] = 16'h8000;
    resetDut();
    checkOutput("trap_fetch", {imemReq, imemAddr}, {1'b1, RESET_PC});
    imemValid = 1'b1;
    imemData = 16'h8000;
    @(negedge clk);
    imemValid = 1'b0;
    checkIdle("trap_decode");
    @(negedge clk);
    repeat (5) begin
      checkOutput("trap_halt", {trap, imemReq, dmemRd, dmemWr}, 4'b1000);
      imemValid = 1'($urandom_range(0, 1));
      dmemAck = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    resetDut();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
